hs_queue: RTL and testbench
===========================

Name: hs_queue

Overview:
- Parametrised successor to the team's single-channel circular queue.
- Same job: a synchronous FIFO with combinational read of the head entry.
- Adds valid/ready handshakes on both sides and arbitrary (non-power-of-two) depth.
- Adds run-time-invariant mode selection (block or overwrite-oldest), programmable almost-full/almost-empty thresholds, and sticky overflow / saturating drop accounting.
- Sits between a producer and a consumer stage anywhere a bounded buffer is needed.

Parameters:
- DATA, 42, width of data bus; any value >= 1.
- DEPTH, 32, number of entries; any value >= 2, no power-of-two requirement.
- ADDR, $clog2(DEPTH), pointer width; derived, never overridden.
- OVERWRITE, 0, 0 = block when full; 1 = push when full discards oldest entry.
- AF_LEVEL, DEPTH-2, almost_full asserted when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL.
- DROPW, 16, width of drop counter.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  producer has data
- in_ready  out  1  queue accepts data this cycle
- in_data  in  DATA  write data
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer takes head this cycle
- out_data  out  DATA  head entry, combinational from storage
- count  out  ADDR+1  occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- overflow  out  1  sticky: push refused while full (OVERWRITE=0 only)
- drop_cnt  out  DROPW  saturating count of entries discarded by overwrite

Behaviour:
- Reset is synchronous: rst high at a rising edge clears wr_ptr, rd_ptr, count, overflow and drop_cnt.
  - After reset: empty=1, full=0, out_valid=0, almost_empty=1, almost_full=(AF_LEVEL==0).
  - Storage is not reset; out_data is don't-care while out_valid=0.
  - rst mid-operation discards all contents and any same-cycle push or pop.
- Handshake:
  - push = in_valid && in_ready.
  - pop = out_valid && out_ready.
  - out_valid = !empty.
  - in_ready = !full, or 1 when OVERWRITE=1.
  - in_ready and out_valid never depend combinationally on in_valid or out_ready.
- Write and read timing:
  - A push writes storage[wr_ptr] at the edge.
  - Data is visible on out_data the cycle after it becomes the head.
  - Minimum latency is 1 cycle, with no fall-through when empty.
- Pointers:
  - Each pointer increments modulo DEPTH: the value DEPTH-1 wraps to 0, including for non-power-of-two DEPTH.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both pointers advance.
  - Push and pop together while empty: only the push occurs, because out_valid=0.
- Full with OVERWRITE=1:
  - A push without a pop writes at wr_ptr and advances both pointers; count stays DEPTH.
  - drop_cnt increments and saturates at all-ones.
  - A push with a pop while full is a normal exchange with no drop.
- Full with OVERWRITE=0:
  - in_valid while full sets overflow for that cycle and it stays set until rst.
  - Data is not written and pointers do not move.
- drop_cnt stays 0 when OVERWRITE=0; overflow stays 0 when OVERWRITE=1.
- Flags full, empty, almost_full and almost_empty are combinational from registered count.
- Invariants:
  - count == (wr_ptr - rd_ptr) mod DEPTH, except count==DEPTH when pointers are equal and full.
  - count never exceeds DEPTH.
  - full and empty are never both high.

Decomposition:
- Package hs_queue_pkg holds:
  - function next_ptr(ptr, DEPTH) for modulo increment;
  - typedef for the mode enum (MODE_BLOCK, MODE_OVERWRITE);
  - default constants for AF/AE levels.
- Sub-module queue_ptr is the wrapping pointer register (clk, rst, inc, ptr), instantiated twice.
- Storage, count and flags stay in hs_queue.

Test Plan:
- DEPTH=5, OVERWRITE=0: push 1..5 -> full=1, in_ready=0, count=5. Pop 5 times -> out_data 1,2,3,4,5 in order, then empty=1.
- DEPTH=5: 12 alternating push/pop cycles -> pointers wrap past 4 to 0, data intact, count never >1.
- DEPTH=4, OVERWRITE=1: push 1..6 with no pops -> count=4, drop_cnt=2, pops return 3,4,5,6.
- OVERWRITE=0, full, in_valid=1 -> overflow=1 and remains 1 after 3 pops; storage unchanged; rst clears it.
- Empty with push and pop in the same cycle -> count=1, out_valid=1 next cycle. Full with push and pop -> count stays DEPTH, drop_cnt unchanged.
- Fill to 3 (AF_LEVEL=3, AE_LEVEL=1), then assert rst with in_valid=1 -> next cycle count=0, empty=1, almost_empty=1, nothing stored.

Source files
------------

// File: rtl/hs_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hs_queue_pkg
// Description : Shared types, defaults and pointer helper for hs_queue.
// Revision    : 1.0 - initial release
// ============================================================================
package hs_queue_pkg;

    typedef enum logic {
        MODE_BLOCK     = 1'b0,
        MODE_OVERWRITE = 1'b1
    } mode_e;

    // Almost-full default sits this many entries below DEPTH.
    localparam int c_af_margin  = 2;
    localparam int c_ae_default = 2;

    // Modulo-DEPTH increment; works for any DEPTH, not just powers of two.
    function automatic int next_ptr(input int ptr, input int depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/queue_ptr.sv
`default_nettype none
// ============================================================================
// Module      : queue_ptr
// Description : Wrapping read/write pointer register for hs_queue.
// Revision    : 1.0 - initial release
// ============================================================================
module queue_ptr
    import hs_queue_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int ADDR  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    output logic [ADDR-1:0] ptr
);

    logic [ADDR-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= ADDR'(next_ptr(int'(r_ptr), DEPTH));
        end
    end

    assign ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/hs_queue.sv
`default_nettype none
// ============================================================================
// Module      : hs_queue
// Description : Valid/ready FIFO, any depth, block or overwrite-oldest mode.
// Revision    : 1.0 - initial release
// ============================================================================
module hs_queue
    import hs_queue_pkg::*;
#(
    parameter int DATA      = 42,
    parameter int DEPTH     = 32,
    parameter int ADDR      = $clog2(DEPTH),
    parameter int OVERWRITE = 0,
    parameter int AF_LEVEL  = DEPTH - c_af_margin,
    parameter int AE_LEVEL  = c_ae_default,
    parameter int DROPW     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DATA-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DATA-1:0]  out_data,
    output logic [ADDR:0]    count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow,
    output logic [DROPW-1:0] drop_cnt
);

    localparam mode_e         c_mode  = (OVERWRITE != 0) ? MODE_OVERWRITE : MODE_BLOCK;
    localparam logic [ADDR:0] c_depth = (ADDR+1)'(DEPTH);
    localparam logic [ADDR:0] c_af    = (ADDR+1)'(AF_LEVEL);
    localparam logic [ADDR:0] c_ae    = (ADDR+1)'(AE_LEVEL);

    logic [DATA-1:0] r_mem [DEPTH];
    logic [ADDR:0]   r_count;
    logic [ADDR-1:0] w_wr_ptr;
    logic [ADDR-1:0] w_rd_ptr;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_drop;

    assign w_full  = (r_count == c_depth);
    assign w_empty = (r_count == '0);

    // Handshake outputs depend only on registered state.
    assign in_ready  = (c_mode == MODE_OVERWRITE) ? 1'b1 : !w_full;
    assign out_valid = !w_empty;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    queue_ptr #(.DEPTH(DEPTH), .ADDR(ADDR)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (w_push),
        .ptr (w_wr_ptr)
    );

    // A drop retires the oldest entry, so the read side advances with it.
    queue_ptr #(.DEPTH(DEPTH), .ADDR(ADDR)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (w_pop || w_drop),
        .ptr (w_rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[w_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_push && !w_pop && !w_full) begin
            r_count <= r_count + (ADDR+1)'(1);
        end else if (w_pop && !w_push) begin
            r_count <= r_count - (ADDR+1)'(1);
        end
    end

    generate
        if (c_mode == MODE_OVERWRITE) begin : g_overwrite
            logic [DROPW-1:0] r_drop_cnt;

            assign w_drop = w_push && !w_pop && w_full;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_drop_cnt <= '0;
                end else if (w_drop && (r_drop_cnt != '1)) begin
                    r_drop_cnt <= r_drop_cnt + DROPW'(1);
                end
            end

            assign drop_cnt = r_drop_cnt;
            assign overflow = 1'b0;
        end else begin : g_block
            logic r_overflow;

            assign w_drop = 1'b0;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_overflow <= 1'b0;
                end else if (in_valid && w_full) begin
                    r_overflow <= 1'b1;
                end
            end

            assign drop_cnt = '0;
            assign overflow = r_overflow;
        end
    endgenerate

    assign out_data     = r_mem[w_rd_ptr];
    assign count        = r_count;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= c_af);
    assign almost_empty = (r_count <= c_ae);

endmodule
`default_nettype wire

// File: tb/tb_hs_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_hs_queue
// Description : Directed self-checking bench: block mode (DEPTH 5) and overwrite mode (DEPTH 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hs_queue;

    localparam int c_data_a = 42;
    localparam int c_data_b = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Instance A: DEPTH 5, blocking, AF_LEVEL 3, AE_LEVEL 1
    logic                a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0;
    logic [c_data_a-1:0] a_in_data = '0, a_out_data;
    logic [3:0]          a_count;
    logic                a_full, a_empty, a_af, a_ae, a_overflow;
    logic [15:0]         a_drop;

    hs_queue #(.DATA(c_data_a), .DEPTH(5), .OVERWRITE(0), .AF_LEVEL(3), .AE_LEVEL(1)) u_dut_a (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (a_in_valid),
        .in_ready     (a_in_ready),
        .in_data      (a_in_data),
        .out_valid    (a_out_valid),
        .out_ready    (a_out_ready),
        .out_data     (a_out_data),
        .count        (a_count),
        .full         (a_full),
        .empty        (a_empty),
        .almost_full  (a_af),
        .almost_empty (a_ae),
        .overflow     (a_overflow),
        .drop_cnt     (a_drop)
    );

    // Instance B: DEPTH 4, overwrite-oldest, default levels (AF 2, AE 2)
    logic                b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0;
    logic [c_data_b-1:0] b_in_data = '0, b_out_data;
    logic [2:0]          b_count;
    logic                b_full, b_empty, b_af, b_ae, b_overflow;
    logic [15:0]         b_drop;

    hs_queue #(.DATA(c_data_b), .DEPTH(4), .OVERWRITE(1)) u_dut_b (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (b_in_valid),
        .in_ready     (b_in_ready),
        .in_data      (b_in_data),
        .out_valid    (b_out_valid),
        .out_ready    (b_out_ready),
        .out_data     (b_out_data),
        .count        (b_count),
        .full         (b_full),
        .empty        (b_empty),
        .almost_full  (b_af),
        .almost_empty (b_ae),
        .overflow     (b_overflow),
        .drop_cnt     (b_drop)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then observed 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("a_rst_empty",    a_empty, 1);
        chk("a_rst_full",     a_full, 0);
        chk("a_rst_outvalid", a_out_valid, 0);
        chk("a_rst_count",    a_count, 0);
        chk("a_rst_ae",       a_ae, 1);
        chk("a_rst_af",       a_af, 0);
        chk("a_rst_inready",  a_in_ready, 1);
        chk("a_rst_overflow", a_overflow, 0);
        chk("b_rst_empty",    b_empty, 1);
        chk("b_rst_drop",     b_drop, 0);

        // Fill 1..5
        a_in_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            a_in_data = c_data_a'(i);
            tick();
            chk("a_fill_count", a_count, i);
            chk("a_fill_af", a_af, (i >= 3) ? 1 : 0);
            chk("a_fill_ae", a_ae, (i <= 1) ? 1 : 0);
            chk("a_fill_head", a_out_data, 1);
        end
        chk("a_full",        a_full, 1);
        chk("a_full_inready", a_in_ready, 0);
        chk("a_full_empty",  a_empty, 0);

        // Push attempt while full
        a_in_data = c_data_a'(99);
        tick();
        a_in_valid = 1'b0;
        chk("a_overflow_set", a_overflow, 1);
        chk("a_overflow_count", a_count, 5);
        chk("a_drop_zero", a_drop, 0);

        // Drain in order; overflow stays sticky
        a_out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            chk("a_drain_data", a_out_data, i);
            tick();
            chk("a_drain_count", a_count, 5 - i);
            chk("a_drain_overflow", a_overflow, 1);
        end
        a_out_ready = 1'b0;
        chk("a_drain_empty", a_empty, 1);
        chk("a_drain_outvalid", a_out_valid, 0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("a_overflow_clr", a_overflow, 0);

        // Push and pop together while empty: only the push happens
        a_in_valid = 1'b1;
        a_out_ready = 1'b1;
        a_in_data = c_data_a'(7);
        tick();
        a_in_valid = 1'b0;
        a_out_ready = 1'b0;
        chk("a_pp_empty_count", a_count, 1);
        chk("a_pp_empty_valid", a_out_valid, 1);
        chk("a_pp_empty_data", a_out_data, 7);
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        chk("a_pp_empty_drain", a_count, 0);

        // Alternating push/pop drives both pointers across the 4->0 wrap
        for (int k = 0; k < 12; k++) begin
            if (k % 2 == 0) begin
                a_in_valid = 1'b1;
                a_in_data = c_data_a'(20 + k);
                tick();
                a_in_valid = 1'b0;
                chk("a_alt_count1", a_count, 1);
            end else begin
                chk("a_alt_data", a_out_data, 20 + k - 1);
                a_out_ready = 1'b1;
                tick();
                a_out_ready = 1'b0;
                chk("a_alt_count0", a_count, 0);
            end
        end

        // Fill to 3 then reset with in_valid held high
        a_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_in_data = c_data_a'(40 + i);
            tick();
        end
        chk("a_pre_rst_count", a_count, 3);
        chk("a_pre_rst_af", a_af, 1);
        rst = 1'b1;
        a_in_data = c_data_a'(50);
        tick();
        rst = 1'b0;
        a_in_valid = 1'b0;
        chk("a_midrst_count", a_count, 0);
        chk("a_midrst_empty", a_empty, 1);
        chk("a_midrst_ae", a_ae, 1);
        chk("a_midrst_valid", a_out_valid, 0);
        tick();
        chk("a_midrst_idle", a_count, 0);

        // Overwrite mode: push 1..6 into DEPTH 4
        b_in_valid = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            b_in_data = c_data_b'(i);
            tick();
            chk("b_fill_inready", b_in_ready, 1);
        end
        chk("b_ow_count", b_count, 4);
        chk("b_ow_drop", b_drop, 2);
        chk("b_ow_full", b_full, 1);
        chk("b_ow_overflow", b_overflow, 0);
        chk("b_ow_head", b_out_data, 3);

        // Exchange while full: no drop
        b_out_ready = 1'b1;
        b_in_data = c_data_b'(7);
        tick();
        b_in_valid = 1'b0;
        chk("b_xchg_count", b_count, 4);
        chk("b_xchg_drop", b_drop, 2);
        for (int i = 4; i <= 7; i++) begin
            chk("b_drain_data", b_out_data, i);
            tick();
        end
        b_out_ready = 1'b0;
        chk("b_drain_empty", b_empty, 1);
        chk("b_drain_count", b_count, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
